// File: rtl/gauss_line_buffer.sv
// Vertical alignment stage for the 3x3 Gaussian filter: keeps the two previous
// image rows and emits the (r-2, r-1, r) pixel column for every pixel of row 2 onward.
module gauss_line_buffer #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_pixel,
    input  logic       i_pixel_valid,
    output logic       o_pixel_ack,
    output logic [7:0] o_pixel_1,
    output logic [7:0] o_pixel_2,
    output logic [7:0] o_pixel_3,
    output logic       o_pixel_valid,
    input  logic       i_pixel_ack,
    output logic       o_col_last
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FIRST_OUT = RW'(2);

    logic [7:0]    l1_mem_q [IMG_WIDTH];
    logic [7:0]    l2_mem_q [IMG_WIDTH];
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    pix1_q, pix1_d;
    logic [7:0]    pix2_q, pix2_d;
    logic [7:0]    pix3_q, pix3_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          accept_s, xfer_s, emit_s, col_wrap_s;
    logic [7:0]    l1_rd_s, l2_rd_s;

    // The one-deep output register frees itself in the same cycle it is consumed.
    assign o_pixel_ack = ~valid_q | i_pixel_ack;
    assign accept_s    = i_pixel_valid & o_pixel_ack;
    assign xfer_s      = valid_q & i_pixel_ack;
    assign col_wrap_s  = (col_q == COL_LAST);
    assign emit_s      = accept_s & (row_q >= ROW_FIRST_OUT);
    assign l1_rd_s     = l1_mem_q[col_q];
    assign l2_rd_s     = l2_mem_q[col_q];

    // Next-state for raster counters and the output column register.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        pix1_d  = pix1_q;
        pix2_d  = pix2_q;
        pix3_d  = pix3_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (accept_s) begin
            if (col_wrap_s) begin
                col_d = {CW{1'b0}};
                if (row_q == ROW_LAST) begin
                    row_d = {RW{1'b0}};
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
                row_d = row_q;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
        if (emit_s) begin
            pix1_d  = l2_rd_s;
            pix2_d  = l1_rd_s;
            pix3_d  = i_pixel;
            last_d  = col_wrap_s;
            valid_d = 1'b1;
        end else if (xfer_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Line memories shift down one row at the current column; contents need no reset.
    always_ff @(posedge i_clk) begin
        if (accept_s) begin
            l2_mem_q[col_q] <= l1_rd_s;
            l1_mem_q[col_q] <= i_pixel;
        end
    end

    // Counter and output register state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col_q   <= {CW{1'b0}};
            row_q   <= {RW{1'b0}};
            pix1_q  <= 8'd0;
            pix2_q  <= 8'd0;
            pix3_q  <= 8'd0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            pix1_q  <= pix1_d;
            pix2_q  <= pix2_d;
            pix3_q  <= pix3_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign o_pixel_1     = pix1_q;
    assign o_pixel_2     = pix2_q;
    assign o_pixel_3     = pix3_q;
    assign o_col_last    = last_q;
    assign o_pixel_valid = valid_q;

endmodule

// File: doc/gauss_line_buffer.md
# gauss_line_buffer

Raster-to-column line buffer that feeds the 3x3 Gaussian filter stage in the gaussian user-logic pipeline. It accepts one 8-bit pixel per transfer in raster order and stores the two previous image rows. For every pixel of row 2 onward, it emits the vertically aligned three-pixel column (row r-2, r-1, r) on the same valid/ack handshake the filter consumes. The filter does the horizontal windowing; this block does only the vertical alignment and the frame/row bookkeeping.

## Interface
Parameters:
- IMG_WIDTH, 512: pixels per row; range 2..4096.
- IMG_HEIGHT, 512: rows per frame; range 3..4096.

Ports:
- i_clk  input  1  single clock; all logic on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_pixel  input  8  raster-order input pixel.
- i_pixel_valid  input  1  upstream has a pixel on i_pixel.
- o_pixel_ack  output  1  block can accept; a transfer occurs on a cycle with i_pixel_valid & o_pixel_ack.
- o_pixel_1  output  8  column pixel from row r-2 (oldest).
- o_pixel_2  output  8  column pixel from row r-1.
- o_pixel_3  output  8  column pixel from row r (current).
- o_pixel_valid  output  1  o_pixel_1..3 hold an unconsumed column.
- i_pixel_ack  input  1  downstream accepts; an output transfer occurs on o_pixel_valid & i_pixel_ack.
- o_col_last  output  1  qualifies the current output column as column IMG_WIDTH-1; meaningful only while o_pixel_valid.

## Operation
- Storage: two line memories, L1 (row r-1) and L2 (row r-2), each IMG_WIDTH x 8. Reads are combinational or read-first, and both memories are addressed by the column counter col.
- Counters: col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1). Both advance only on an accepted input. col wraps to 0 at IMG_WIDTH-1 and increments row at that point. row wraps to 0 at IMG_HEIGHT-1, which starts a new frame.
- On each accepted pixel p at (row, col), in one cycle:
  - L2[col] <= L1[col] (old value).
  - L1[col] <= p.
  - If row >= 2: o_pixel_1 <= old L2[col], o_pixel_2 <= old L1[col], o_pixel_3 <= p, o_col_last <= (col == IMG_WIDTH-1), and o_pixel_valid <= 1.
- Priming: rows 0 and 1 of every frame are stored only and produce no output. Each frame therefore emits exactly IMG_WIDTH*(IMG_HEIGHT-2) columns. Line memories are not cleared between frames; priming overwrites them.
- Output register is one entry deep. o_pixel_ack = ~o_pixel_valid | i_pixel_ack (combinational).
- o_pixel_valid next-state rules:
  - An accepted input with row >= 2 sets it.
  - Otherwise, an output transfer clears it.
  - Otherwise, it holds.
- Simultaneous output transfer and accepted input with row >= 2: the register reloads with the new column and valid stays 1, giving full throughput of one pixel per cycle.
- Simultaneous output transfer and accepted input with row < 2 (the first rows of the next frame): valid clears and the input is stored.
- Stall: while o_pixel_valid & ~i_pixel_ack, o_pixel_ack = 0. No input is accepted, and outputs and counters hold. Memory is written only on an accepted input.
- i_pixel_valid may drop at any time. Idle cycles change nothing.

## Timing
- Reset (async assert, sync use after release):
  - o_pixel_valid = 0, o_col_last = 0, o_pixel_1..3 = 0.
  - col = 0, row = 0.
  - o_pixel_ack = 1 during and after reset.
  - Memory contents are undefined but are never emitted before being rewritten.
- Reset mid-frame: any held output is discarded. The next accepted pixel is treated as row 0, col 0 of a new frame.
- Latency: input accepted at edge t produces o_pixel_valid = 1 and its data after edge t, visible in cycle t+1.
- Output data and o_col_last are stable while o_pixel_valid & ~i_pixel_ack.
- No combinational path from i_pixel_valid to any output. The only combinational path is i_pixel_ack -> o_pixel_ack.

## Test plan
Use IMG_WIDTH=4, IMG_HEIGHT=4, and pixel value = 16*row + col.

- Continuous stream, i_pixel_ack held 1:
  - Rows 0-1 produce no valid.
  - Row 2 col 1 -> (0x01, 0x11, 0x21) one cycle after acceptance.
  - Row 3 col 3 -> (0x13, 0x23, 0x33) with o_col_last = 1.
  - Exactly 8 outputs per frame.
- Backpressure: hold i_pixel_ack = 0 for 5 cycles while the output for row 2 col 0 is valid.
  - o_pixel_ack = 0 and (0x00, 0x10, 0x20) stays stable.
  - The held column is the next output after ack; no pixel is lost or duplicated.
- Two back-to-back frames, second frame value = 0x80 + 16*row + col:
  - Frame 2 first output is row 2 col 0 = (0x80, 0x90, 0xA0).
  - No frame-1 data leaks into it.
- Random i_pixel_valid gaps and random i_pixel_ack: a scoreboard matches every output against a reference model, in order.
- Async reset asserted mid row 2 with o_pixel_valid = 1:
  - o_pixel_valid drops immediately.
  - Restreaming a full frame produces the same 8 outputs as the first scenario.
- Row wrap at IMG_WIDTH-1 occurring during a stall: col and row do not advance until the input is accepted.
